// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter with round-robin, registered grant.
// Optional slave-hang watchdog enabled by defining WB_ARB_TIMEOUT_EN.
`default_nettype none

module wb_arbiter_2m #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic [1:0]      grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   lru_q, lru_d;
   logic   abort_s;
   logic   to_err_s;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         lru_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         lru_q   <= lru_d;
      end
   end

   // On a tie the master that was not served last wins.
   always_comb begin
      state_d = state_q;
      lru_d   = lru_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_d = lru_q ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_d = GNT0;
            else if (m1_cyc_i)        state_d = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_d = IDLE;
               lru_d   = 1'b0;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_d = IDLE;
               lru_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      grant_o  = 2'b00;
      case (state_q)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i & ~abort_s;
            s_stb_o  = m0_stb_i & ~abort_s;
            m0_ack_o = s_ack_i & ~abort_s & ~reset;
            m0_err_o = ((s_err_i & ~abort_s) | to_err_s) & ~reset;
            grant_o  = 2'b01;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i & ~abort_s;
            s_stb_o  = m1_stb_i & ~abort_s;
            m1_ack_o = s_ack_i & ~abort_s & ~reset;
            m1_err_o = ((s_err_i & ~abort_s) | to_err_s) & ~reset;
            grant_o  = 2'b10;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          abort_q, abort_d;
   logic          to_err_q, to_err_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         abort_q  <= 1'b0;
         to_err_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         abort_q  <= abort_d;
         to_err_q <= to_err_d;
      end
   end

   // Abort drops s_stb_o, which clears the counter, so the error pulse fires once.
   always_comb begin
      cnt_d    = cnt_q;
      to_err_d = 1'b0;
      if (!s_stb_o || s_ack_i || s_err_i || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d    = '0;
         to_err_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      abort_d = (abort_q | to_err_d) & (state_d != IDLE);
   end

   assign abort_s  = abort_q;
   assign to_err_s = to_err_q;
`else
   assign abort_s  = 1'b0;
   assign to_err_s = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// Directed, table-driven bench for wb_arbiter_2m plus multi-cycle corner sequences.
`default_nettype none

module tb_wb_arbiter_2m;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack, s_err;
   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
   logic [1:0]  grant_o;

   int n_total = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o)
   );

   typedef struct {
      logic       c0, s0, c1, s1, ack, err;
      logic [1:0] g;
      logic       scyc;
      logic [31:0] adr, dat;
      logic [3:0] flags;   // {m0_ack, m1_ack, m0_err, m1_err}
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, return at the following negedge.
   task automatic cyc(input logic c0, s0, c1, s1, ack, err);
      @(posedge clock);
      #1;
      m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack; s_err = err;
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      reset  = 1'b1;
      m0_adr = 32'h10; m0_dat = 32'h1111_1111; m0_sel = 4'h3; m0_we = 1'b0;
      m1_adr = 32'h20; m1_dat = 32'hA5A5_A5A5; m1_sel = 4'hC; m1_we = 1'b1;
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
      s_dat_i = 32'hDEAD_BEEF;

      vt[0]  = '{0,0,0,0,0,0, 2'b00, 0, 32'h0,  32'h0,         4'b0000};
      vt[1]  = '{1,1,0,0,0,0, 2'b00, 0, 32'h0,  32'h0,         4'b0000};
      vt[2]  = '{1,1,0,0,0,0, 2'b01, 1, 32'h10, 32'h1111_1111, 4'b0000};
      vt[3]  = '{1,1,0,0,1,0, 2'b01, 1, 32'h10, 32'h1111_1111, 4'b1000};
      vt[4]  = '{0,0,1,1,0,0, 2'b01, 0, 32'h10, 32'h1111_1111, 4'b0000};
      vt[5]  = '{0,0,1,1,0,0, 2'b00, 0, 32'h0,  32'h0,         4'b0000};
      vt[6]  = '{0,0,1,1,0,1, 2'b10, 1, 32'h20, 32'hA5A5_A5A5, 4'b0001};
      vt[7]  = '{1,1,1,1,1,0, 2'b10, 1, 32'h20, 32'hA5A5_A5A5, 4'b0100};
      vt[8]  = '{1,1,0,0,0,0, 2'b10, 0, 32'h20, 32'hA5A5_A5A5, 4'b0000};
      vt[9]  = '{1,1,1,1,1,0, 2'b00, 0, 32'h0,  32'h0,         4'b0000};
      vt[10] = '{1,1,1,1,0,0, 2'b01, 1, 32'h10, 32'h1111_1111, 4'b0000};
      vt[11] = '{1,1,1,1,0,1, 2'b01, 1, 32'h10, 32'h1111_1111, 4'b0010};
      vt[12] = '{0,0,1,1,0,0, 2'b01, 0, 32'h10, 32'h1111_1111, 4'b0000};
      vt[13] = '{0,0,1,1,0,0, 2'b00, 0, 32'h0,  32'h0,         4'b0000};
      vt[14] = '{0,0,1,1,0,0, 2'b10, 1, 32'h20, 32'hA5A5_A5A5, 4'b0000};

      // Reset state
      do_reset();
      chk("reset grant", 32'(grant_o), 32'h0);
      chk("reset s_cyc", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'h0);
      chk("reset s_adr", s_adr_o, 32'h0);
      chk("reset acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'h0);

      // Table-driven vectors
      for (int i = 0; i < 15; i++) begin
         cyc(vt[i].c0, vt[i].s0, vt[i].c1, vt[i].s1, vt[i].ack, vt[i].err);
         chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(vt[i].g));
         chk($sformatf("v%0d s_cyc", i), 32'(s_cyc_o), 32'(vt[i].scyc));
         chk($sformatf("v%0d s_adr", i), s_adr_o, vt[i].adr);
         chk($sformatf("v%0d s_dat", i), s_dat_o, vt[i].dat);
         chk($sformatf("v%0d ack/err", i),
             32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'(vt[i].flags));
      end
      chk("m0 read data", m0_dat_o, 32'hDEAD_BEEF);
      chk("m1 read data", m1_dat_o, 32'hDEAD_BEEF);

      // Tie after reset: m0 first, then m1 after one idle cycle
      do_reset();
      cyc(1,1,1,1,0,0);
      chk("tie idle grant", 32'(grant_o), 32'h0);
      cyc(1,1,1,1,0,0);
      chk("tie m0 wins", 32'(grant_o), 32'h1);
      cyc(0,0,1,1,0,0);
      chk("tie hold m0", 32'(grant_o), 32'h1);
      cyc(0,0,1,1,0,0);
      chk("tie gap idle", 32'(grant_o), 32'h0);
      cyc(0,0,1,1,0,0);
      chk("tie m1 grant", 32'(grant_o), 32'h2);
      chk("tie m1 data", s_dat_o, 32'hA5A5_A5A5);

      // Fairness: both keep requesting, grants must alternate m0,m1,...
      do_reset();
      for (int k = 0; k < 8; k++) begin
         cyc(1,1,1,1,0,0);
         chk($sformatf("fair%0d idle", k), 32'(grant_o), 32'h0);
         cyc(1,1,1,1,1,0);
         chk($sformatf("fair%0d grant", k), 32'(grant_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("fair%0d ack", k), 32'({m0_ack_o, m1_ack_o}),
             (k % 2 == 0) ? 32'h2 : 32'h1);
         if (k % 2 == 0) cyc(0,0,1,1,0,0);
         else            cyc(1,1,0,0,0,0);
      end

      // Reset mid-transfer while m1 owns the bus
      do_reset();
      cyc(0,0,1,1,0,0);
      cyc(0,0,1,1,0,0);
      chk("rst pre grant", 32'(grant_o), 32'h2);
      @(posedge clock);
      #1;
      reset = 1'b1; s_ack = 1'b1;
      @(negedge clock);
      chk("rst no ack", 32'(m1_ack_o), 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0; s_ack = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
      @(negedge clock);
      chk("rst s_cyc drop", 32'(s_cyc_o), 32'h0);
      chk("rst grant idle", 32'(grant_o), 32'h0);
      cyc(1,1,1,1,0,0);
      chk("rst m0 wins", 32'(grant_o), 32'h1);

`ifdef WB_ARB_TIMEOUT_EN
      // Watchdog: stb rises at k=0, error pulse at k=16, bus held off afterwards
      do_reset();
      cyc(1,1,0,0,0,0);
      for (int k = 0; k < 19; k++) begin
         cyc(1,1,0,0,0,0);
         chk($sformatf("wd%0d err", k), 32'(m0_err_o), (k == 16) ? 32'h1 : 32'h0);
         chk($sformatf("wd%0d s_cyc", k), 32'(s_cyc_o), (k < 16) ? 32'h1 : 32'h0);
      end
      cyc(1,1,0,0,1,0);
      chk("wd late ack", 32'({m0_ack_o, s_cyc_o}), 32'h0);
      cyc(0,0,0,0,0,0);
      cyc(1,1,0,0,0,0);
      chk("wd idle", 32'(grant_o), 32'h0);
      cyc(1,1,0,0,0,0);
      chk("wd regrant", 32'({grant_o, s_cyc_o}), 32'b011);
`endif

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule

`default_nettype wire
